dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the processor's single-port, synchronous-read data memory between two requesters.
  - Port 0: CPU load/store unit.
  - Port 1: debug/DMA loader, which preloads or inspects data memory while the core runs.
- Issues at most one memory access per cycle.
- Round-robin arbitration, returning a one-cycle-later response to the winner.
- Sits between the core's datapath and the data memory inside the top-level processor.

Parameters:
- ADDR_W, 8, data-memory address width
- DATA_W, 16, data word width
- LOCK_MAX, 4, maximum consecutive locked grants (used only with ARB_LOCK_EN)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req0  in  1  port 0 access request; payload held stable while req0=1 and gnt0=0
- we0  in  1  port 0 write enable (1=write, 0=read)
- addr0  in  ADDR_W  port 0 address
- wdata0  in  DATA_W  port 0 write data
- lock0  in  1  port 0 lock request (see Optional Feature)
- gnt0  out  1  port 0 access issued this cycle (combinational)
- rvalid0  out  1  port 0 response valid (registered)
- req1, we1, addr1, wdata1, lock1  in  same as port 0, for port 1
- gnt1  out  1  same as gnt0, for port 1
- rvalid1  out  1  same as rvalid0, for port 1
- rdata  out  DATA_W  shared response data, qualified by rvalid0/rvalid1
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_en with mem_we=0

Behaviour:
- Reset (synchronous, active-high):
  - rvalid0 = rvalid1 = 0, rdata = 0.
  - Round-robin pointer last = 1, so port 0 wins the first tie.
  - Lock state cleared.
  - Combinational outputs are 0 while reset is high: gnt0, gnt1, mem_en, mem_we.
- Grant selection (combinational, each cycle):
  - Only req0: gnt0.
  - Only req1: gnt1.
  - Both: grant the port != last.
  - Neither: no grant; mem_en = 0 and mem_addr/mem_wdata/mem_we = 0.
  - gnt0 and gnt1 are never high together.
- Issue: on a grant, mem_en=1 and mem_we/mem_addr/mem_wdata are taken from the granted port. last updates to the granted port at the clock edge.
- Response:
  - Cycle N+1 after a grant in cycle N, rvalidX pulses for exactly 1 cycle.
  - Reads: rdata = mem_rdata.
  - Writes: rdata = 0; the pulse serves as the write acknowledgment.
  - Requires a registered was_read/owner pair.
  - Neither rvalid is high: rdata = 0.
- Throughput: back-to-back grants allowed; a requester holding req continuously gets one access per cycle when alone. With both requesting, grants alternate 0,1,0,1...
- Withdrawal: a requester may drop req before being granted; nothing is issued and no response follows.
- Reset mid-operation: any in-flight response is discarded, so no rvalid the cycle after reset. A write issued in the same cycle that reset is high is not issued, since mem_en is forced 0.
- Payload change while waiting: undefined for the requester. The arbiter samples payload only in the grant cycle.

Optional Feature:
- Macro ARB_LOCK_EN.
- Defined:
  - If the granted port has lockX=1 in its grant cycle, it becomes owner.
  - While owner keeps reqX && lockX, only owner is eligible; the other port waits regardless of round-robin.
  - Lock ends when owner drops req or lock, or after LOCK_MAX consecutive locked grants. On forced release the other port, if requesting, wins next.
  - A locked counter (width ceil(log2(LOCK_MAX+1))) tracks the consecutive grants.
  - Reset clears ownership.
- Undefined: lock0/lock1 remain ports but are ignored; pure round-robin.

Test Plan:
- Reset held 2 cycles then released with no requests -> all outputs 0, mem_en=0.
- After reset:
  - Port 0 write addr=0x10 data=0x1234: gnt0 cycle N with mem_we=1, rvalid0 cycle N+1 with rdata=0.
  - Port 0 read addr=0x10 next: rvalid0 cycle N+3 with rdata=0x1234.
- req0 and req1 held 6 cycles from reset (reads of 0x01/0x02) -> grant sequence 0,1,0,1,0,1; each rvalid one cycle after its grant, never both high.
- Port 1 raises req then drops it in a cycle where port 0 is granted -> no gnt1, no rvalid1, no memory access for port 1.
- Port 1 read granted cycle N, reset asserted cycle N+1 -> rvalid1=0 and rdata=0 in N+1 and N+2; after release, tie goes to port 0.
- With ARB_LOCK_EN, LOCK_MAX=4: port 0 holds req+lock while port 1 requests -> four consecutive gnt0, then gnt1. Without the macro -> alternating 0,1.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data memory between the CPU (port 0)
// and a debug/DMA loader (port 1). Define ARB_LOCK_EN to let a granted port hold the memory.
module dmem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              lock0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic r_last;      // port granted most recently; the other port wins a tie
  logic r_rvalid0;
  logic r_rvalid1;
  logic r_was_read;
  logic w_elig0;
  logic w_elig1;
  logic w_gnt0;
  logic w_gnt1;

`ifdef ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic             r_locked;
  logic             r_owner;
  logic [CNT_W-1:0] r_lock_cnt;
  logic             w_gnt_lock;

  assign w_gnt_lock = w_gnt0 ? lock0 : (w_gnt1 & lock1);

  // Counter saturating at LOCK_MAX ends the lock; the owner's next grant starts a fresh one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_locked   <= 1'b0;
      r_owner    <= 1'b0;
      r_lock_cnt <= '0;
    end else if (w_gnt_lock) begin
      if (r_locked && (r_owner == w_gnt1) && (r_lock_cnt < CNT_W'(LOCK_MAX))) begin
        r_lock_cnt <= r_lock_cnt + CNT_W'(1);
      end else begin
        r_locked   <= 1'b1;
        r_owner    <= w_gnt1;
        r_lock_cnt <= CNT_W'(1);
      end
    end else begin
      r_locked   <= 1'b0;
      r_lock_cnt <= '0;
    end
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = lock0 ^ lock1 ^ (LOCK_MAX == 0);
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    w_elig0 = req0;
    w_elig1 = req1;
    w_gnt0  = 1'b0;
    w_gnt1  = 1'b0;
`ifdef ARB_LOCK_EN
    if (r_locked && (r_lock_cnt < CNT_W'(LOCK_MAX))) begin
      if (!r_owner && req0 && lock0) w_elig1 = 1'b0;
      if (r_owner && req1 && lock1)  w_elig0 = 1'b0;
    end
`endif
    if (!reset) begin
      if (w_elig0 && w_elig1) begin
        w_gnt0 = r_last;
        w_gnt1 = !r_last;
      end else begin
        w_gnt0 = w_elig0;
        w_gnt1 = w_elig1;
      end
    end
  end

  assign gnt0      = w_gnt0;
  assign gnt1      = w_gnt1;
  assign mem_en    = w_gnt0 | w_gnt1;
  assign mem_we    = w_gnt0 ? we0    : (w_gnt1 ? we1    : 1'b0);
  assign mem_addr  = w_gnt0 ? addr0  : (w_gnt1 ? addr1  : '0);
  assign mem_wdata = w_gnt0 ? wdata0 : (w_gnt1 ? wdata1 : '0);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      r_last     <= 1'b1;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_was_read <= 1'b0;
    end else begin
      r_rvalid0  <= w_gnt0;
      r_rvalid1  <= w_gnt1;
      r_was_read <= mem_en & ~mem_we;
      if (mem_en) r_last <= w_gnt1;
    end
  end

  // A response in flight when reset rises is dropped immediately, not one cycle later.
  assign rvalid0 = r_rvalid0 & ~reset;
  assign rvalid1 = r_rvalid1 & ~reset;
  assign rdata   = ((rvalid0 | rvalid1) && r_was_read) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural reference model compared every cycle,
// plus directed scenarios with literal expectations. Honours ARB_LOCK_EN like the design.
module tb_dmem_arbiter;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 16;
  localparam int LOCK_MAX = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0, we0, lock0, req1, we1, lock1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
    .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    return {8'hA5, a};
  endfunction

  // Synchronous-read memory; unwritten locations return a recognisable pattern.
  logic [DATA_W-1:0] tb_mem [256];
  bit                tb_wr  [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        tb_mem[mem_addr] <= mem_wdata;
        tb_wr[mem_addr]  <= 1'b1;
      end else begin
        mem_rdata <= tb_wr[mem_addr] ? tb_mem[mem_addr] : init_val(mem_addr);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: winner by the round-robin rule, a one-entry response pipe, shadow memory.
  logic [DATA_W-1:0] sh_mem [256];
  bit                sh_wr  [256];
  bit                m_last = 1'b1;
  bit                p_v = 1'b0, p_port, p_rd;
  logic [DATA_W-1:0] p_data;
  bit                m_locked = 1'b0, m_owner = 1'b0;
  int                m_cnt = 0;

  always @(negedge clk) begin
    bit                e0, e1, g0, g1, ev0, ev1, een, ewe, glock;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ewd, erd;
    e0 = req0; e1 = req1; g0 = 0; g1 = 0;
`ifdef ARB_LOCK_EN
    if (m_locked && m_cnt < LOCK_MAX) begin
      if (!m_owner && req0 && lock0) e1 = 0;
      if (m_owner && req1 && lock1)  e0 = 0;
    end
`endif
    if (!reset) begin
      if (e0 && e1) begin
        if (m_last) g0 = 1; else g1 = 1;
      end else begin
        g0 = e0; g1 = e1;
      end
    end
    een = g0 || g1;
    ewe = g0 ? we0 : (g1 ? we1 : 1'b0);
    ea  = g0 ? addr0 : (g1 ? addr1 : '0);
    ewd = g0 ? wdata0 : (g1 ? wdata1 : '0);
    ev0 = !reset && p_v && !p_port;
    ev1 = !reset && p_v && p_port;
    erd = ((ev0 || ev1) && p_rd) ? p_data : '0;

    check("gnt0", gnt0, g0);
    check("gnt1", gnt1, g1);
    check("mem_en", mem_en, een);
    check("mem_we", mem_we, ewe);
    check("mem_addr", mem_addr, ea);
    check("mem_wdata", mem_wdata, ewd);
    check("rvalid0", rvalid0, ev0);
    check("rvalid1", rvalid1, ev1);
    check("rdata", rdata, erd);

    if (reset) begin
      p_v = 0; m_last = 1; m_locked = 0; m_cnt = 0;
    end else begin
      p_v = een;
      if (een) begin
        p_port = g1;
        p_rd   = !ewe;
        if (ewe) begin
          sh_mem[ea] = ewd;
          sh_wr[ea]  = 1;
        end else begin
          p_data = sh_wr[ea] ? sh_mem[ea] : init_val(ea);
        end
        m_last = g1;
      end
      glock = g0 ? lock0 : (g1 && lock1);
      if (glock) begin
        if (m_locked && m_owner == g1 && m_cnt < LOCK_MAX) m_cnt++;
        else begin
          m_locked = 1; m_owner = g1; m_cnt = 1;
        end
      end else begin
        m_locked = 0; m_cnt = 0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0; lock0 = 0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; lock1 = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit exp_rr [6];
    bit exp_lk [6];
    exp_rr = '{0, 1, 0, 1, 0, 1};
`ifdef ARB_LOCK_EN
    exp_lk = '{0, 0, 0, 0, 1, 0};
`else
    exp_lk = '{0, 1, 0, 1, 0, 1};
`endif
    reset = 1;
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // Idle after reset.
    @(negedge clk);
    check("idle_gnt", {gnt0, gnt1}, 2'b00);
    check("idle_mem_en", mem_en, 1'b0);
    check("idle_rvalid", {rvalid0, rvalid1}, 2'b00);
    check("idle_rdata", rdata, 16'h0000);

    // Port 0 write 0x1234 to 0x10, idle, then read it back.
    next_cycle();
    req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 16'h1234;
    @(negedge clk);
    check("wr_gnt0", gnt0, 1'b1);
    check("wr_mem_we", mem_we, 1'b1);
    check("wr_mem_addr", mem_addr, 8'h10);
    check("wr_mem_wdata", mem_wdata, 16'h1234);
    next_cycle();
    idle();
    @(negedge clk);
    check("wr_ack_rvalid0", rvalid0, 1'b1);
    check("wr_ack_rdata", rdata, 16'h0000);
    next_cycle();
    req0 = 1; addr0 = 8'h10;
    @(negedge clk);
    check("rd_gnt0", gnt0, 1'b1);
    check("rd_mem_we", mem_we, 1'b0);
    next_cycle();
    idle();
    @(negedge clk);
    check("rd_rvalid0", rvalid0, 1'b1);
    check("rd_rdata", rdata, 16'h1234);

    // Both requesting from reset: strict alternation starting with port 0.
    next_cycle();
    reset = 1;
    next_cycle();
    reset = 0;
    req0 = 1; addr0 = 8'h01; req1 = 1; addr1 = 8'h02;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rr_gnt0", gnt0, !exp_rr[i]);
      check("rr_gnt1", gnt1, exp_rr[i]);
      if (i < 5) next_cycle();
    end
    next_cycle();
    idle();

    // Port 1 withdraws while port 0 holds the grant.
    next_cycle();
    req0 = 1; addr0 = 8'h03; req1 = 1; addr1 = 8'h04;
    @(negedge clk);
    check("wd_gnt0", gnt0, 1'b1);
    check("wd_gnt1", gnt1, 1'b0);
    next_cycle();
    idle();
    @(negedge clk);
    check("wd_rvalid0", rvalid0, 1'b1);
    check("wd_rvalid1", rvalid1, 1'b0);
    check("wd_mem_en", mem_en, 1'b0);

    // Reset lands on a port 1 read response; it must vanish, then port 0 wins the tie.
    next_cycle();
    req1 = 1; addr1 = 8'h20;
    @(negedge clk);
    check("rst_gnt1", gnt1, 1'b1);
    next_cycle();
    reset = 1; idle();
    @(negedge clk);
    check("rst_rvalid1_a", rvalid1, 1'b0);
    check("rst_rdata_a", rdata, 16'h0000);
    next_cycle();
    reset = 0;
    req0 = 1; addr0 = 8'h05; req1 = 1; addr1 = 8'h06;
    @(negedge clk);
    check("rst_rvalid1_b", rvalid1, 1'b0);
    check("rst_rdata_b", rdata, 16'h0000);
    check("rst_tie_gnt0", gnt0, 1'b1);
    next_cycle();
    idle();

    // Port 0 requests with lock while port 1 competes.
    next_cycle();
    reset = 1;
    next_cycle();
    reset = 0;
    req0 = 1; lock0 = 1; addr0 = 8'h07; req1 = 1; addr1 = 8'h08;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("lk_gnt0", gnt0, !exp_lk[i]);
      check("lk_gnt1", gnt1, exp_lk[i]);
      if (i < 5) next_cycle();
    end
    next_cycle();
    idle();
    repeat (3) next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
